// File: rtl/alien_fire_pkg.sv
// Shared types and default sizing for the alien fire scheduler.
// The state encoding lives here so benches and neighbours can name states.
package alien_fire_pkg;

    localparam int NUM_COLS_DEFAULT   = 11;
    localparam int COL_BITS_DEFAULT   = 4;
    localparam int MIN_DELAY_DEFAULT  = 2;
    localparam int RAND_BITS_DEFAULT  = 8;
    localparam int DELAY_BITS_DEFAULT = 6;
    localparam int CNT_BITS_DEFAULT   = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ_DLY,
        ST_CAP_DLY,
        ST_WAIT,
        ST_REQ_COL,
        ST_CAP_COL,
        ST_SCAN,
        ST_FIRE
    } fire_state_e;

endpackage

// File: rtl/alien_fire_scheduler.sv
// Picks a random delay, then a random live column, and requests an alien shot.
// Talks to an external random generator through a rise/dout handshake.
module alien_fire_scheduler
    import alien_fire_pkg::*;
#(
    parameter int NUM_COLS   = NUM_COLS_DEFAULT,
    parameter int COL_BITS   = COL_BITS_DEFAULT,
    parameter int RAND_BITS  = RAND_BITS_DEFAULT,
    parameter int DELAY_BITS = DELAY_BITS_DEFAULT,
    parameter int MIN_DELAY  = MIN_DELAY_DEFAULT,
    parameter int CNT_BITS   = CNT_BITS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 tick,
    output logic                 rand_rise,
    input  logic [RAND_BITS-1:0] rand_val,
    input  logic [NUM_COLS-1:0]  col_alive,
    output logic                 fire_req,
    output logic [COL_BITS-1:0]  fire_col,
    input  logic                 fire_ack
);

    localparam int PAD_W = 2 ** COL_BITS;

    fire_state_e         state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [COL_BITS-1:0] idx_q, idx_d;
    logic [COL_BITS-1:0] scan_q, scan_d;
    logic [COL_BITS-1:0] fire_col_q, fire_col_d;
    logic                rand_rise_q, rand_rise_d;
    logic                fire_req_q, fire_req_d;

    logic [PAD_W-1:0]    alive_pad;
    logic [COL_BITS-1:0] col_raw;
    logic                unused_rand;

    // Padding lets idx address every code of COL_BITS; phantom columns read dead.
    assign alive_pad   = PAD_W'(col_alive);
    assign col_raw     = rand_val[COL_BITS-1:0];
    assign unused_rand = ^rand_val;

    // NOTE: every variable gets a default before the case, otherwise any path
    // that skips an assignment infers a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        scan_d     = scan_q;
        fire_col_d = fire_col_q;

        // A pending shot is never withdrawn; everything else stops on disable.
        if (!enable && state_q != ST_FIRE) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:    state_d = ST_REQ_DLY;
                ST_REQ_DLY: state_d = ST_CAP_DLY;
                ST_CAP_DLY: begin
                    cnt_d   = CNT_BITS'(MIN_DELAY) + CNT_BITS'(rand_val[DELAY_BITS-1:0]);
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (tick) begin
                        if (cnt_q <= CNT_BITS'(1)) state_d = ST_REQ_COL;
                        else                       cnt_d   = cnt_q - CNT_BITS'(1);
                    end
                end
                ST_REQ_COL: state_d = ST_CAP_COL;
                ST_CAP_COL: begin
                    idx_d   = ({1'b0, col_raw} >= (COL_BITS+1)'(NUM_COLS))
                            ? col_raw - COL_BITS'(NUM_COLS) : col_raw;
                    scan_d  = '0;
                    state_d = ST_SCAN;
                end
                ST_SCAN: begin
                    if (alive_pad[idx_q]) begin
                        fire_col_d = idx_q;
                        state_d    = ST_FIRE;
                    end else if (scan_q == COL_BITS'(NUM_COLS - 1)) begin
                        state_d = ST_REQ_DLY;
                    end else begin
                        idx_d  = (idx_q == COL_BITS'(NUM_COLS - 1)) ? '0 : idx_q + COL_BITS'(1);
                        scan_d = scan_q + COL_BITS'(1);
                    end
                end
                ST_FIRE: begin
                    if (fire_ack) state_d = enable ? ST_REQ_DLY : ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Outputs are decoded from the next state so they register with it.
        rand_rise_d = (state_d == ST_REQ_DLY) || (state_d == ST_REQ_COL);
        fire_req_d  = (state_d == ST_FIRE);
    end

    // NOTE: state updates use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            scan_q      <= '0;
            fire_col_q  <= '0;
            rand_rise_q <= 1'b0;
            fire_req_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            scan_q      <= scan_d;
            fire_col_q  <= fire_col_d;
            rand_rise_q <= rand_rise_d;
            fire_req_q  <= fire_req_d;
        end
    end

    assign rand_rise = rand_rise_q;
    assign fire_req  = fire_req_q;
    assign fire_col  = fire_col_q;

endmodule

// File: tb/tb_alien_fire_scheduler.sv
// Self-checking bench for alien_fire_scheduler with a queued random-generator
// model and a scoreboard of expected shot columns.
module tb_alien_fire_scheduler;
    import alien_fire_pkg::*;

    localparam int NC  = 11;
    localparam int CB  = 4;
    localparam int RB  = 8;
    localparam int MIN = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          tick;
    logic          rand_rise;
    logic [RB-1:0] rand_val;
    logic [NC-1:0] col_alive;
    logic          fire_req;
    logic [CB-1:0] fire_col;
    logic          fire_ack;

    int tests = 0;
    int fails = 0;

    logic [RB-1:0] rand_q[$];
    int            sb_q[$];

    alien_fire_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .tick      (tick),
        .rand_rise (rand_rise),
        .rand_val  (rand_val),
        .col_alive (col_alive),
        .fire_req  (fire_req),
        .fire_col  (fire_col),
        .fire_ack  (fire_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    // Generator model: on a rise strobe, present the next queued value.
    task automatic wait_rise(input int budget, output int waited);
        waited = -1;
        for (int i = 0; i <= budget; i++) begin
            if (rand_rise === 1'b1) begin
                waited = i;
                if (rand_q.size() > 0) rand_val = rand_q.pop_front();
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_round(input string name, input logic [RB-1:0] dly_val,
                             input logic [RB-1:0] col_val, input logic [NC-1:0] alive,
                             input bit exp_fire, input int exp_col, input int exp_lat,
                             input bit ack_noise);
        int  d;
        int  w;
        int  lat;
        int  exp_c;
        bit  early;
        rand_q.push_back(dly_val);
        rand_q.push_back(col_val);
        col_alive = alive;
        if (exp_fire) sb_q.push_back(exp_col);
        wait_rise(20, w);
        tests++;
        if (w < 0) begin
            fails++;
            $display("FAIL %s_dly_rise: no rand_rise seen, required one within 20 cycles", name);
        end
        d = MIN + int'(dly_val[5:0]);
        @(negedge clk);
        @(negedge clk);
        fire_ack = ack_noise;
        early = 1'b0;
        for (int i = 1; i < d; i++) begin
            pulse_tick();
            if (rand_rise !== 1'b0) early = 1'b1;
            @(negedge clk);
        end
        fire_ack = 1'b0;
        tests++;
        if (early) begin
            fails++;
            $display("FAIL %s_early: rand_rise before tick %0d, required none", name, d);
        end
        pulse_tick();
        wait_rise(4, w);
        tests++;
        if (w !== 0) begin
            fails++;
            $display("FAIL %s_delay: col rand_rise after %0d extra cycles, required 0 after tick %0d",
                     name, w, d);
        end
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (fire_req === 1'b1 || rand_rise === 1'b1) break;
        end
        tests++;
        if (fire_req !== exp_fire) begin
            fails++;
            $display("FAIL %s_fire_req: got %b, required %b", name, fire_req, exp_fire);
        end
        tests++;
        if (lat !== exp_lat) begin
            fails++;
            $display("FAIL %s_latency: got %0d cycles, required %0d", name, lat, exp_lat);
        end
        if (fire_req === 1'b1) begin
            exp_c = (sb_q.size() > 0) ? sb_q.pop_front() : -1;
            tests++;
            if (int'(fire_col) !== exp_c) begin
                fails++;
                $display("FAIL %s_fire_col: got %0d, required %0d", name, fire_col, exp_c);
            end
        end
    endtask

    task automatic ack_hold(input string name, input int n_hold, input int drop_at);
        logic [CB-1:0] c;
        bit            bad;
        c   = fire_col;
        bad = 1'b0;
        for (int i = 0; i < n_hold; i++) begin
            @(negedge clk);
            if (i == drop_at) enable = 1'b0;
            if (fire_req !== 1'b1 || fire_col !== c) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL %s_hold: fire_req/fire_col moved while unacked, required stable 1/%0d", name, c);
        end
        fire_ack = 1'b1;
        @(negedge clk);
        fire_ack = 1'b0;
        tests++;
        if (fire_req !== 1'b0) begin
            fails++;
            $display("FAIL %s_ack_drop: fire_req %b after ack, required 0", name, fire_req);
        end
    endtask

    task automatic check_quiet(input string name, input int n);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (rand_rise !== 1'b0 || fire_req !== 1'b0) seen = 1'b1;
        end
        tests++;
        if (seen) begin
            fails++;
            $display("FAIL %s_quiet: activity seen over %0d cycles, required none", name, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; tick = 1'b0; fire_ack = 1'b0;
        rand_val = '0; col_alive = '0;
        repeat (3) @(negedge clk);
        tests++;
        if ({rand_rise, fire_req, fire_col} !== '0 || dut.state_q !== ST_IDLE) begin
            fails++;
            $display("FAIL reset_state: rise=%b req=%b col=%0d state=%0d, required all 0 / IDLE",
                     rand_rise, fire_req, fire_col, dut.state_q);
        end
        reset = 1'b0;
        check_quiet("reset_idle", 4);
    endtask

    task automatic test_delay_fire();
        enable = 1'b1;
        run_round("delay_fire", 8'h05, 8'h03, '1, 1'b1, 3, 3, 1'b0);
        ack_hold("delay_fire", 2, -1);
    endtask

    task automatic test_scan_wrap();
        run_round("scan_offset", 8'h00, 8'h0D, 11'b000_0010_0000, 1'b1, 5, 6, 1'b1);
        ack_hold("scan_offset", 0, -1);
    endtask

    task automatic test_no_alive();
        run_round("no_alive", 8'hFF, 8'h07, '0, 1'b0, 0, 13, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_round("wrap_col", 8'h01, 8'h0A, 11'b000_0000_0001, 1'b1, 0, 4, 1'b0);
        ack_hold("wrap_col", 1, -1);
    endtask

    task automatic test_fire_hold();
        run_round("fire_hold", 8'h02, 8'h08, '1, 1'b1, 8, 3, 1'b0);
        ack_hold("fire_hold", 20, 5);
        tests++;
        if (dut.state_q !== ST_IDLE) begin
            fails++;
            $display("FAIL fire_hold_idle: state %0d, required IDLE", dut.state_q);
        end
        check_quiet("fire_hold", 10);
    endtask

    task automatic test_reset_mid_wait();
        int w;
        rand_q.delete();
        rand_q.push_back(8'h10);
        enable = 1'b1;
        wait_rise(10, w);
        @(negedge clk);
        @(negedge clk);
        pulse_tick();
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if ({rand_rise, fire_req, fire_col} !== '0 || dut.state_q !== ST_IDLE || dut.cnt_q !== '0) begin
            fails++;
            $display("FAIL reset_mid_wait: rise=%b req=%b col=%0d state=%0d cnt=%0d, required 0/0/0/IDLE/0",
                     rand_rise, fire_req, fire_col, dut.state_q, dut.cnt_q);
        end
        reset  = 1'b0;
        enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_enable_drop();
        int w;
        rand_q.delete();
        rand_q.push_back(8'h00);
        enable = 1'b1;
        wait_rise(10, w);
        @(negedge clk);
        @(negedge clk);
        tick   = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        tick = 1'b0;
        tests++;
        if (dut.state_q !== ST_IDLE || rand_rise !== 1'b0) begin
            fails++;
            $display("FAIL enable_drop: state=%0d rise=%b, required IDLE/0", dut.state_q, rand_rise);
        end
        check_quiet("enable_drop", 5);
    endtask

    initial begin
        test_reset();
        test_delay_fire();
        test_scan_wrap();
        test_no_alive();
        test_back_to_back();
        test_fire_hold();
        test_reset_mid_wait();
        test_enable_drop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alien_fire_scheduler.md
ALIEN_FIRE_SCHEDULER -- requirements
Module: alien_fire_scheduler

Interface
REQ-001 Parameter NUM_COLS, default 11, number of alien columns.
REQ-002 Parameter COL_BITS, default 4, width of column index; 2^COL_BITS >= NUM_COLS.
REQ-003 Parameter RAND_BITS, default 8, width of random value input.
REQ-004 Parameter DELAY_BITS, default 6, random bits used for fire delay.
REQ-005 Parameter MIN_DELAY, default 2, minimum ticks between shots; must be >= 1.
REQ-006 Parameter CNT_BITS, default 8, delay counter width; must hold MIN_DELAY + 2^DELAY_BITS - 1.
REQ-007 clk  in  1  single clock; all logic on rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 enable  in  1  game running; level.
REQ-010 tick  in  1  one-cycle frame-start pulse; delay time base.
REQ-011 rand_rise  out  1  request strobe to the random generator's rise input.
REQ-012 rand_val  in  RAND_BITS  value from the random generator's dout.
REQ-013 col_alive  in  NUM_COLS  bit i = column i has a live alien.
REQ-014 fire_req  out  1  shot request to missile block.
REQ-015 fire_col  out  COL_BITS  column of requested shot.
REQ-016 fire_ack  in  1  missile block accepted shot.

Function
REQ-017 The block SHALL implement states IDLE, REQ_DLY, CAP_DLY, WAIT, REQ_COL, CAP_COL, SCAN, FIRE; all outputs registered.
REQ-018 IDLE: enable=1 -> REQ_DLY; else stay.
REQ-019 REQ_DLY and REQ_COL SHALL drive rand_rise=1 for exactly one cycle; rand_rise=0 in all other states, guaranteeing >= 1 low cycle between pulses.
REQ-020 rand_val SHALL be sampled in the cycle immediately after a rand_rise pulse (generator latches on its rise rising edge).
REQ-021 CAP_DLY: cnt <= MIN_DELAY + rand_val[DELAY_BITS-1:0] (zero-extended to CNT_BITS) -> WAIT.
REQ-022 WAIT: on tick, if cnt <= 1 -> REQ_COL, else cnt <= cnt-1; exactly D ticks elapse for loaded D.
REQ-023 CAP_COL: idx = rand_val[COL_BITS-1:0]; if idx >= NUM_COLS then idx <= idx - NUM_COLS; clear scan count -> SCAN.
REQ-024 SCAN: one column per cycle; if col_alive[idx] -> fire_col <= idx, FIRE; else idx <= (idx == NUM_COLS-1) ? 0 : idx+1, scan count +1.
REQ-025 SCAN: after NUM_COLS dead columns checked -> REQ_DLY with no shot.
REQ-026 FIRE: fire_req=1, fire_col stable until the cycle fire_ack=1 is sampled; then fire_req=0 next cycle, -> REQ_DLY.
REQ-027 fire_ack outside FIRE SHALL be ignored.
REQ-028 enable=0 in any state except FIRE -> IDLE next cycle, rand_rise=0.
REQ-029 enable=0 in FIRE SHALL NOT drop fire_req; after ack -> IDLE.
REQ-030 tick outside WAIT SHALL be ignored; tick and enable fall in same WAIT cycle -> IDLE takes priority.

Reset
REQ-031 reset=1 SHALL, on the next clk edge, force IDLE, rand_rise=0, fire_req=0, fire_col=0, cnt=0, idx=0, scan count=0, regardless of state.
REQ-032 reset SHALL take priority over enable, tick and fire_ack.

Structure
REQ-033 Package alien_fire_pkg SHALL hold the state enum type and default constants NUM_COLS, COL_BITS, MIN_DELAY.
REQ-034 No sub-module; the random generator is instantiated beside this block, not inside it.

Verification (NUM_COLS=11, MIN_DELAY=2)
REQ-035 Reset mid-WAIT -> next cycle all outputs 0, state IDLE.
REQ-036 enable=1, first rand_val=0x05 -> 7 ticks then rand_rise pulse; second rand_val=0x03, col_alive=all ones -> fire_req=1, fire_col=3.
REQ-037 Column rand_val=0x0D, col_alive=11'b000_0010_0000 -> idx 2, scans 2,3,4,5 -> fire_col=5 on 4th SCAN cycle.
REQ-038 col_alive=0 -> 11 SCAN cycles, no fire_req, rand_rise pulses again (REQ_DLY).
REQ-039 fire_ack held off 20 cycles, enable dropped at cycle 5 -> fire_req/fire_col stable throughout; after ack fire_req=0, state IDLE, no further rand_rise.
